// File: rtl/intra_edge_fetch.sv
// Intra edge builder: fetches the corner, above row and left column for one block
// from the reconstructed-pixel store, then applies edge replication and frame-edge fills.
module intra_edge_fetch #(
  parameter int BIT_DEPTH = 10,
  parameter int MAX_LOG2  = 4,
  parameter int FRAME_W   = 1920,
  parameter int FRAME_H   = 1080,
  parameter int RD_LAT    = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     req_valid,
  output logic                                     req_ready,
  input  logic [15:0]                              req_x,
  input  logic [15:0]                              req_y,
  input  logic [3:0]                               req_log2w,
  input  logic [3:0]                               req_log2h,
  input  logic                                     req_have_ar,
  input  logic                                     req_have_bl,
  output logic                                     rd_en,
  output logic [15:0]                              rd_x,
  output logic [15:0]                              rd_y,
  input  logic [BIT_DEPTH-1:0]                     rd_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic                                     have_left,
  output logic                                     have_above,
  output logic [BIT_DEPTH-1:0]                     corner,
  output logic [2*(1<<MAX_LOG2)*BIT_DEPTH-1:0]     above_row,
  output logic [2*(1<<MAX_LOG2)*BIT_DEPTH-1:0]     left_col
);

  localparam int EDGE = 2 << MAX_LOG2;
  localparam int IW   = MAX_LOG2 + 1;
  localparam int CW   = MAX_LOG2 + 2;
  localparam logic [BIT_DEPTH-1:0] MID    = {1'b1, {(BIT_DEPTH-1){1'b0}}};
  localparam logic [BIT_DEPTH-1:0] MID_M1 = {1'b0, {(BIT_DEPTH-1){1'b1}}};
  localparam logic [BIT_DEPTH-1:0] MID_P1 = {1'b1, {(BIT_DEPTH-2){1'b0}}, 1'b1};
  localparam logic [16:0] X_MAX    = 17'(FRAME_W - 1);
  localparam logic [16:0] Y_MAX    = 17'(FRAME_H - 1);
  localparam logic [3:0]  LOG2_MAX = 4'(MAX_LOG2);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FILL, S_DONE} state_t;
  typedef enum logic [1:0] {P_CORNER, P_ABOVE, P_LEFT, P_END} part_t;

  state_t               state_q;
  part_t                part_q, tk_q;
  logic [IW-1:0]        idx_q, ti_q;
  logic [15:0]          x_q, y_q, rd_x_q, rd_y_q;
  logic [CW-1:0]        na_q, nl_q;
  logic                 have_l_q, have_a_q, rd_en_q, out_valid_q, req_ready_q;
  logic [RD_LAT:1]      pv_q;
  part_t                pk_q [1:RD_LAT];
  logic [IW-1:0]        pi_q [1:RD_LAT];
  logic [BIT_DEPTH-1:0] corner_q;
  logic [BIT_DEPTH-1:0] above_q [EDGE];
  logic [BIT_DEPTH-1:0] left_q  [EDGE];

  logic [3:0]    lw_d, lh_d;
  logic [CW-1:0] w_d, h_d, na_d, nl_d, na_m1, nl_m1;
  logic          l_d, a_d, pending;
  logic [16:0]   ax_sum, ly_sum;
  logic [15:0]   ax_clamp, ly_clamp;

  always_comb begin
    lw_d     = (req_log2w < 4'd2) ? 4'd2 : ((req_log2w > LOG2_MAX) ? LOG2_MAX : req_log2w);
    lh_d     = (req_log2h < 4'd2) ? 4'd2 : ((req_log2h > LOG2_MAX) ? LOG2_MAX : req_log2h);
    w_d      = CW'(1) << lw_d;
    h_d      = CW'(1) << lh_d;
    l_d      = (req_x != 16'd0);
    a_d      = (req_y != 16'd0);
    na_d     = (a_d && req_have_ar) ? (w_d << 1) : w_d;
    nl_d     = (l_d && req_have_bl) ? (h_d << 1) : h_d;
    na_m1    = na_q - CW'(1);
    nl_m1    = nl_q - CW'(1);
    // 17-bit sums so positions past the frame clamp instead of wrapping
    ax_sum   = {1'b0, x_q} + 17'(idx_q);
    ly_sum   = {1'b0, y_q} + 17'(idx_q);
    ax_clamp = (ax_sum > X_MAX) ? X_MAX[15:0] : ax_sum[15:0];
    ly_clamp = (ly_sum > Y_MAX) ? Y_MAX[15:0] : ly_sum[15:0];
    pending  = rd_en_q;
    for (int s = 1; s < RD_LAT; s++) pending = pending | pv_q[s];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      part_q      <= P_END;
      idx_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      na_q        <= '0;
      nl_q        <= '0;
      have_l_q    <= 1'b0;
      have_a_q    <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_x_q      <= '0;
      rd_y_q      <= '0;
      tk_q        <= P_CORNER;
      ti_q        <= '0;
      pv_q        <= '0;
      for (int s = 1; s <= RD_LAT; s++) begin
        pk_q[s] <= P_CORNER;
        pi_q[s] <= '0;
      end
      corner_q    <= '0;
      for (int i = 0; i < EDGE; i++) begin
        above_q[i] <= '0;
        left_q[i]  <= '0;
      end
      out_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      // Destination tags travel alongside the store latency
      pv_q[1] <= rd_en_q;
      pk_q[1] <= tk_q;
      pi_q[1] <= ti_q;
      for (int s = 2; s <= RD_LAT; s++) begin
        pv_q[s] <= pv_q[s-1];
        pk_q[s] <= pk_q[s-1];
        pi_q[s] <= pi_q[s-1];
      end
      if (pv_q[RD_LAT]) begin
        case (pk_q[RD_LAT])
          P_CORNER: corner_q <= rd_data;
          P_ABOVE:  above_q[pi_q[RD_LAT]] <= rd_data;
          P_LEFT:   left_q[pi_q[RD_LAT]] <= rd_data;
          default:  ;
        endcase
      end
      rd_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            x_q         <= req_x;
            y_q         <= req_y;
            have_l_q    <= l_d;
            have_a_q    <= a_d;
            na_q        <= na_d;
            nl_q        <= nl_d;
            idx_q       <= '0;
            part_q      <= (l_d || a_d) ? P_CORNER : P_END;
            req_ready_q <= 1'b0;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          case (part_q)
            P_CORNER: begin
              rd_en_q <= 1'b1;
              rd_x_q  <= have_l_q ? x_q - 16'd1 : x_q;
              rd_y_q  <= have_a_q ? y_q - 16'd1 : y_q;
              tk_q    <= P_CORNER;
              ti_q    <= '0;
              idx_q   <= '0;
              part_q  <= have_a_q ? P_ABOVE : (have_l_q ? P_LEFT : P_END);
            end
            P_ABOVE: begin
              rd_en_q <= 1'b1;
              rd_x_q  <= ax_clamp;
              rd_y_q  <= y_q - 16'd1;
              tk_q    <= P_ABOVE;
              ti_q    <= idx_q;
              if (idx_q == na_m1[IW-1:0]) begin
                idx_q  <= '0;
                part_q <= have_l_q ? P_LEFT : P_END;
              end else begin
                idx_q  <= idx_q + IW'(1);
              end
            end
            P_LEFT: begin
              rd_en_q <= 1'b1;
              rd_x_q  <= x_q - 16'd1;
              rd_y_q  <= ly_clamp;
              tk_q    <= P_LEFT;
              ti_q    <= idx_q;
              if (idx_q == nl_m1[IW-1:0]) begin
                idx_q  <= '0;
                part_q <= P_END;
              end else begin
                idx_q  <= idx_q + IW'(1);
              end
            end
            default: state_q <= S_DRAIN;
          endcase
        end
        S_DRAIN: begin
          if (!pending) state_q <= S_FILL;
        end
        S_FILL: begin
          for (int i = 0; i < EDGE; i++) begin
            if (have_a_q) begin
              if (CW'(i) >= na_q) above_q[i] <= above_q[na_m1[IW-1:0]];
            end else if (have_l_q) begin
              above_q[i] <= corner_q;
            end else begin
              above_q[i] <= MID_M1;
            end
            if (have_l_q) begin
              if (CW'(i) >= nl_q) left_q[i] <= left_q[nl_m1[IW-1:0]];
            end else if (have_a_q) begin
              left_q[i] <= corner_q;
            end else begin
              left_q[i] <= MID_P1;
            end
          end
          if (!have_a_q && !have_l_q) corner_q <= MID;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rd_en      = rd_en_q;
  assign rd_x       = rd_x_q;
  assign rd_y       = rd_y_q;
  assign out_valid  = out_valid_q;
  assign have_left  = have_l_q;
  assign have_above = have_a_q;
  assign corner     = corner_q;

  for (genvar gi = 0; gi < EDGE; gi++) begin : g_pack
    assign above_row[gi*BIT_DEPTH +: BIT_DEPTH] = above_q[gi];
    assign left_col[gi*BIT_DEPTH +: BIT_DEPTH]  = left_q[gi];
  end

endmodule

// File: tb/tb_intra_edge_fetch.sv
// Directed bench for intra_edge_fetch: pixel store model, per-read address checks,
// latency, fill values, output hold and mid-operation reset.
module tb_intra_edge_fetch;
  localparam int BD     = 10;
  localparam int EDGE   = 32;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready;
  logic [15:0]       req_x, req_y;
  logic [3:0]        req_log2w, req_log2h;
  logic              req_have_ar, req_have_bl;
  logic              rd_en;
  logic [15:0]       rd_x, rd_y;
  logic [BD-1:0]     rd_data;
  logic              out_valid, out_ready;
  logic              have_left, have_above;
  logic [BD-1:0]     corner;
  logic [EDGE*BD-1:0] above_row, left_col;

  int checks   = 0;
  int failures = 0;

  int exp_rx[$];
  int exp_ry[$];
  int exp_above[EDGE];
  int exp_left[EDGE];
  int exp_corner;

  always #5 clk = ~clk;

  intra_edge_fetch #(.BIT_DEPTH(BD), .MAX_LOG2(4), .FRAME_W(1920), .FRAME_H(1080), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_log2w(req_log2w), .req_log2h(req_log2h),
    .req_have_ar(req_have_ar), .req_have_bl(req_have_bl),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .have_left(have_left), .have_above(have_above), .corner(corner),
    .above_row(above_row), .left_col(left_col)
  );

  function automatic logic [BD-1:0] pix(input int x, input int y);
    int v;
    v = (x * 7 + y * 31 + 3) % 1000;
    return v[BD-1:0];
  endfunction

  // Store model: not reset, so pre-reset reads keep arriving on rd_data
  logic [BD-1:0] st_q [0:RD_LAT-1];
  always @(posedge clk) begin
    st_q[0] <= rd_en ? pix(int'(rd_x), int'(rd_y)) : '0;
    for (int s = 1; s < RD_LAT; s++) st_q[s] <= st_q[s-1];
  end
  assign rd_data = st_q[RD_LAT-1];

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_rd(input int x, input int y);
    exp_rx.push_back(x);
    exp_ry.push_back(y);
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic clear_exp();
    exp_rx.delete();
    exp_ry.delete();
  endtask

  task automatic run_case(input string name, input int x, input int y, input int lw, input int lh,
                          input int ar, input int bl, input int exp_l, input int exp_a,
                          input int lat, input int hold);
    int nr, cnt, done;
    @(negedge clk);
    req_x = 16'(x); req_y = 16'(y);
    req_log2w = 4'(lw); req_log2h = 4'(lh);
    req_have_ar = ar[0]; req_have_bl = bl[0];
    req_valid = 1'b1;
    check_eq({name, " req_ready"}, int'(req_ready), 1);
    @(posedge clk);
    nr = 0; cnt = 0; done = 0;
    while (done == 0 && cnt < 500) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (out_valid) begin
        done = 1;
      end else begin
        if (rd_en) begin
          if (nr < exp_rx.size()) begin
            check_eq($sformatf("%s rd_x[%0d]", name, nr), int'(rd_x), exp_rx[nr]);
            check_eq($sformatf("%s rd_y[%0d]", name, nr), int'(rd_y), exp_ry[nr]);
          end
          nr++;
        end
        cnt++;
      end
    end
    $display("%s: x=%0d y=%0d reads=%0d latency=%0d", name, x, y, nr, cnt);
    check_eq({name, " done"}, done, 1);
    check_eq({name, " latency"}, cnt, lat);
    check_eq({name, " nreads"}, nr, exp_rx.size());
    check_eq({name, " have_left"}, int'(have_left), exp_l);
    check_eq({name, " have_above"}, int'(have_above), exp_a);
    check_eq({name, " corner"}, int'(corner), exp_corner);
    for (int i = 0; i < EDGE; i++) begin
      check_eq($sformatf("%s above[%0d]", name, i), int'(above_row[i*BD +: BD]), exp_above[i]);
      check_eq($sformatf("%s left[%0d]", name, i), int'(left_col[i*BD +: BD]), exp_left[i]);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq($sformatf("%s hold%0d out_valid", name, h), int'(out_valid), 1);
      check_eq($sformatf("%s hold%0d req_ready", name, h), int'(req_ready), 0);
      check_eq($sformatf("%s hold%0d rd_en", name, h), int'(rd_en), 0);
      check_eq($sformatf("%s hold%0d corner", name, h), int'(corner), exp_corner);
      check_eq($sformatf("%s hold%0d above31", name, h), int'(above_row[31*BD +: BD]), exp_above[31]);
      check_eq($sformatf("%s hold%0d left0", name, h), int'(left_col[BD-1:0]), exp_left[0]);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({name, " release out_valid"}, int'(out_valid), 0);
    check_eq({name, " release req_ready"}, int'(req_ready), 1);
  endtask

  task automatic setup_t2();
    clear_exp();
    push_rd(3, 0);
    for (int j = 0; j < 4; j++) push_rd(3, j);
    exp_corner = int'(pix(3, 0));
    for (int i = 0; i < EDGE; i++) begin
      exp_above[i] = int'(pix(3, 0));
      exp_left[i]  = int'(pix(3, imin(i, 3)));
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; out_ready = 1'b0;
    req_x = '0; req_y = '0; req_log2w = '0; req_log2h = '0;
    req_have_ar = 1'b0; req_have_bl = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset req_ready", int'(req_ready), 1);
    check_eq("reset out_valid", int'(out_valid), 0);
    check_eq("reset rd_en", int'(rd_en), 0);
    check_eq("reset corner", int'(corner), 0);
    check_eq("reset above0", int'(above_row[BD-1:0]), 0);
    check_eq("reset left31", int'(left_col[31*BD +: BD]), 0);
    rst_n = 1'b1;

    // Neither neighbour: constant fills, no reads
    clear_exp();
    exp_corner = 512;
    for (int i = 0; i < EDGE; i++) begin
      exp_above[i] = 511;
      exp_left[i]  = 513;
    end
    run_case("t1_origin", 0, 0, 2, 2, 0, 0, 0, 0, 3, 1);

    // Left only: above row replicates (x-1,y)
    setup_t2();
    run_case("t2_left_only", 4, 0, 2, 2, 0, 0, 1, 0, 9, 0);

    // Right frame edge with above-right: x clamps at 1919
    clear_exp();
    push_rd(1915, 7);
    for (int i = 0; i < 16; i++) push_rd(imin(1916 + i, 1919), 7);
    for (int j = 0; j < 8; j++) push_rd(1915, 8 + j);
    exp_corner = int'(pix(1915, 7));
    for (int i = 0; i < EDGE; i++) begin
      exp_above[i] = int'(pix(imin(1916 + i, 1919), 7));
      exp_left[i]  = int'(pix(1915, 8 + imin(i, 7)));
    end
    run_case("t3_right_edge", 1916, 8, 3, 3, 1, 0, 1, 1, 29, 0);

    // Full 16x16 with both extensions, held 5 cycles
    clear_exp();
    push_rd(7, 7);
    for (int i = 0; i < 32; i++) push_rd(8 + i, 7);
    for (int j = 0; j < 32; j++) push_rd(7, 8 + j);
    exp_corner = int'(pix(7, 7));
    for (int i = 0; i < EDGE; i++) begin
      exp_above[i] = int'(pix(8 + i, 7));
      exp_left[i]  = int'(pix(7, 8 + i));
    end
    run_case("t4_full", 8, 8, 4, 4, 1, 1, 1, 1, 69, 5);

    // Bottom frame edge with below-left: y clamps at 1079
    clear_exp();
    push_rd(7, 1071);
    for (int i = 0; i < 4; i++) push_rd(8 + i, 1071);
    for (int j = 0; j < 32; j++) push_rd(7, imin(1072 + j, 1079));
    exp_corner = int'(pix(7, 1071));
    for (int i = 0; i < EDGE; i++) begin
      exp_above[i] = int'(pix(8 + imin(i, 3), 1071));
      exp_left[i]  = int'(pix(7, imin(1072 + i, 1079)));
    end
    run_case("t5_bottom_edge", 8, 1072, 2, 4, 0, 1, 1, 1, 41, 0);

    // Above only, log2 sizes clamped (0 -> 2, 9 -> 4)
    clear_exp();
    push_rd(0, 15);
    for (int i = 0; i < 8; i++) push_rd(i, 15);
    exp_corner = int'(pix(0, 15));
    for (int i = 0; i < EDGE; i++) begin
      exp_above[i] = int'(pix(imin(i, 7), 15));
      exp_left[i]  = int'(pix(0, 15));
    end
    run_case("t6_above_only", 0, 16, 0, 9, 1, 1, 0, 1, 13, 0);

    // Reset in the middle of ISSUE, then a fresh request
    @(negedge clk);
    req_x = 16'd8; req_y = 16'd8; req_log2w = 4'd4; req_log2h = 4'd4;
    req_have_ar = 1'b1; req_have_bl = 1'b1; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("midrst rd_en_before", int'(rd_en), 1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst req_ready", int'(req_ready), 1);
    check_eq("midrst rd_en", int'(rd_en), 0);
    check_eq("midrst out_valid", int'(out_valid), 0);
    check_eq("midrst have_left", int'(have_left), 0);
    check_eq("midrst corner", int'(corner), 0);
    @(negedge clk);
    rst_n = 1'b1;
    setup_t2();
    run_case("t7_after_reset", 4, 0, 2, 2, 0, 0, 1, 0, 9, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
